layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Central scheduler for the cached dilated causal conv stack.
- Accepts one input sample per handshake and strobes the left shift buffer once.
- Then for each layer in turn: starts that layer's conv1d, waits for its done, and strobes its activation cache; after the last layer, captures the output.
- Adds a per-layer watchdog timeout and a per-sample cycle-count profile; replaces hand-coded per-layer sequencing in the top-level network.

Parameters:
- N_LAYERS, 3, number of conv layers sequenced (2..8).
- TIMEOUT, 64, max WAIT cycles per layer before abort; 0 disables the watchdog.
- CW, 12, width of the cycle-count profile output.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_v  in  1  new input sample available
- sample_ready  out  1  sequencer can accept a sample
- lsb_shift  out  1  one-cycle strobe to the left shift buffer
- conv_start  out  N_LAYERS  one-hot, one-cycle start/reset strobe per conv layer
- conv_done  in  N_LAYERS  per-layer out_v from conv1d
- cache_shift  out  N_LAYERS-1  one-hot, one-cycle strobe to activation cache after layer i
- out_capture  out  1  one-cycle strobe: latch final layer outputs
- out_v  out  1  one-cycle pulse: a network result is complete
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky: a layer failed to finish within TIMEOUT
- err_layer  out  3  index of the layer that timed out
- clr_err  in  1  clears timeout_err and err_layer
- last_cycles  out  CW  cycles from accept to out_v for the last completed sample; saturates at all-ones

Behaviour:
- Reset (async, immediate):
  - state=IDLE, layer index=0, watchdog=0, profile counter=0.
  - All strobes=0; timeout_err=0, err_layer=0, last_cycles=0.
  - Reset mid-sample aborts the sample with no out_v.
- All outputs are decoded from registered state only, with no combinational input-to-output paths.
- States: IDLE, SHIFT, START, WAIT, CACHE, OUTPUT.
- IDLE:
  - sample_ready=1.
  - sample_v=1 accepts the sample: goes to SHIFT, layer=0, profile counter loaded with 1.
  - sample_v while not in IDLE is ignored; the source holds it.
- SHIFT: lsb_shift=1 for this one cycle -> START.
- START:
  - conv_start[layer]=1 for one cycle; watchdog cleared -> WAIT.
  - conv_done is not sampled in START, because stale done from the previous run is possible.
- WAIT: samples conv_done[layer] only; other bits are ignored.
  - done=1 and layer<N_LAYERS-1 -> CACHE.
  - done=1 and layer=N_LAYERS-1 -> OUTPUT.
  - done=0: watchdog increments.
  - TIMEOUT!=0 and watchdog reaches TIMEOUT-1 with done=0: timeout_err=1, err_layer=layer -> IDLE, sample dropped, no out_v.
  - Done and timeout in the same cycle: done wins.
- CACHE: cache_shift[layer]=1 for one cycle, layer increments -> START.
- OUTPUT:
  - out_capture=1 and out_v=1 for one cycle.
  - last_cycles <= profile counter -> IDLE.
- Profile counter increments every non-IDLE cycle and saturates at 2^CW-1.
- Latency: with done on the first WAIT cycle of every layer, N_LAYERS=3:
  - accept at cycle 0, SHIFT at 1, layer0 START/WAIT/CACHE at 2-4, layer1 at 5-7, layer2 START/WAIT at 8-9, OUTPUT at 10.
  - sample_ready returns at 11.
  - Each extra WAIT cycle adds 1.
- timeout_err clearing:
  - clr_err clears timeout_err and err_layer.
  - clr_err in the same cycle as a new timeout: the set wins and the new err_layer is recorded.
  - A timeout does not block further samples.

Test Plan:
- Reset, then sample_v=1 with conv_done echoing conv_start one cycle later -> lsb_shift@1, conv_start=001@2, cache_shift=01@4, conv_start=010@5, cache_shift=10@7, conv_start=100@8, out_v@10, last_cycles=10, sample_ready@11.
- conv_done[1] held high before layer1 starts -> ignored in START; layer1 still takes ≥2 cycles; out_v@10 with no skipped cache_shift.
- Layer1 done never asserted, TIMEOUT=64 -> timeout_err=1, err_layer=1, no out_v or out_capture, cache_shift[1] never pulses, return to IDLE; next sample completes normally.
- clr_err asserted in the same cycle as a second timeout on layer2 -> timeout_err stays 1, err_layer=2.
- rst pulsed while in WAIT of layer1 -> all strobes 0 immediately, busy=0, sample_ready=1 after rst falls, last_cycles=0.
- sample_v held high continuously with done delay 5 -> exactly one lsb_shift per out_v; out_v period = accept-to-out_v latency + 1 cycle.

Source files
------------

// File: rtl/layer_sequencer.sv
// Purpose: central scheduler for the cached dilated causal conv stack; sequences shift, per-layer conv, cache, output.
// Latency: accept->out_v = 2 + 3*N_LAYERS - 1 cycles plus one per extra WAIT cycle (10 for 3 layers, done on first WAIT cycle).
// Backpressure: sample_ready only in IDLE; sample_v is held by the source until accepted. Per-layer watchdog aborts a stuck layer.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sample_v/ready       input sample handshake (accepted in IDLE only)
//   lsb_shift            one-cycle strobe to the left shift buffer
//   conv_start/done      one-hot start strobe per layer / per-layer completion from conv1d
//   cache_shift          one-hot strobe to the activation cache following layer i
//   out_capture, out_v   one-cycle strobes when the final layer has finished
//   busy                 sequencer is not idle
//   timeout_err/err_layer sticky watchdog error and offending layer; cleared by clr_err
//   last_cycles          accept-to-out_v cycle count of the last completed sample (saturating)

module layer_sequencer #(
    parameter int N_LAYERS = 3,
    parameter int TIMEOUT  = 64,
    parameter int CW       = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_v,
    output logic                sample_ready,
    output logic                lsb_shift,
    output logic [N_LAYERS-1:0] conv_start,
    input  logic [N_LAYERS-1:0] conv_done,
    output logic [N_LAYERS-2:0] cache_shift,
    output logic                out_capture,
    output logic                out_v,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          err_layer,
    input  logic                clr_err,
    output logic [CW-1:0]       last_cycles
);
    localparam int LW  = $clog2(N_LAYERS);
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0]       LAST_LAYER = LW'(N_LAYERS - 1);
    localparam logic [WDW-1:0]      WD_LIMIT   = WDW'(TIMEOUT - 1);
    localparam logic [CW-1:0]       PROF_MAX   = '1;
    localparam logic [N_LAYERS-1:0] START_ONE  = N_LAYERS'(1);
    localparam logic [N_LAYERS-2:0] CACHE_ONE  = (N_LAYERS - 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_START,
        ST_WAIT,
        ST_CACHE,
        ST_OUTPUT
    } state_t;

    state_t         state, state_nxt;
    logic [LW-1:0]  layer, layer_nxt;
    logic [WDW-1:0] wd, wd_nxt;
    logic [CW-1:0]  prof, prof_nxt;
    logic           terr_nxt;
    logic [2:0]     elay_nxt;
    logic [CW-1:0]  last_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            layer       <= '0;
            wd          <= '0;
            prof        <= '0;
            timeout_err <= 1'b0;
            err_layer   <= '0;
            last_cycles <= '0;
        end else begin
            state       <= state_nxt;
            layer       <= layer_nxt;
            wd          <= wd_nxt;
            prof        <= prof_nxt;
            timeout_err <= terr_nxt;
            err_layer   <= elay_nxt;
            last_cycles <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        wd_nxt    = wd;
        prof_nxt  = prof;
        terr_nxt  = timeout_err;
        elay_nxt  = err_layer;
        last_nxt  = last_cycles;

        // A clear is overridden below if a timeout fires in the same cycle.
        if (clr_err) begin
            terr_nxt = 1'b0;
            elay_nxt = '0;
        end

        if (state != ST_IDLE && prof != PROF_MAX)
            prof_nxt = prof + 1'b1;

        case (state)
            ST_IDLE: begin
                if (sample_v) begin
                    state_nxt = ST_SHIFT;
                    layer_nxt = '0;
                    prof_nxt  = CW'(1);
                end
            end
            ST_SHIFT: state_nxt = ST_START;
            ST_START: begin
                // conv_done may still show the previous run here, so it is not looked at.
                wd_nxt    = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_done[layer]) begin
                    state_nxt = (layer == LAST_LAYER) ? ST_OUTPUT : ST_CACHE;
                end else if (TIMEOUT != 0 && wd == WD_LIMIT) begin
                    terr_nxt  = 1'b1;
                    elay_nxt  = 3'(layer);
                    state_nxt = ST_IDLE;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            ST_CACHE: begin
                layer_nxt = layer + 1'b1;
                state_nxt = ST_START;
            end
            ST_OUTPUT: begin
                last_nxt  = prof;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state and layer only.
    assign sample_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign lsb_shift    = (state == ST_SHIFT);
    assign conv_start   = (state == ST_START) ? (START_ONE << layer) : '0;
    assign cache_shift  = (state == ST_CACHE) ? (CACHE_ONE << layer) : '0;
    assign out_capture  = (state == ST_OUTPUT);
    assign out_v        = (state == ST_OUTPUT);

endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose: randomized, self-checking bench for layer_sequencer against a timeline model of the schedule.
// Latency: model derives every strobe cycle from accept time and per-layer done delays.
// Backpressure: sample_v held by the bench until accepted; conv_done produced by a delayed responder.

module tb_layer_sequencer;
    localparam int NL     = 3;
    localparam int TO     = 64;
    localparam int MAXC   = 256;
    localparam int VW     = 2 * NL + 4;
    localparam int B_CAP  = 2 * NL;
    localparam int B_OUTV = 2 * NL + 1;
    localparam int B_BUSY = 2 * NL + 2;
    localparam int B_RDY  = 2 * NL + 3;
    localparam logic [VW-1:0] IDLE_VEC = VW'(1) << B_RDY;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_v;
    logic          clr_err;
    logic [NL-1:0] conv_done;

    logic          sample_ready, lsb_shift, out_capture, out_v, busy, timeout_err;
    logic [NL-1:0] conv_start;
    logic [NL-2:0] cache_shift;
    logic [2:0]    err_layer;
    logic [11:0]   last_cycles;

    // Narrow-counter instance sharing all inputs, used to see saturation.
    logic          sm_ready, sm_lsb, sm_cap, sm_outv, sm_busy, sm_terr;
    logic [NL-1:0] sm_start;
    logic [NL-2:0] sm_cache;
    logic [2:0]    sm_el;
    logic [3:0]    sm_last;

    int n_cmp = 0;
    int n_bad = 0;

    logic [VW-1:0] exp_vec [MAXC];
    logic [VW-1:0] obs_vec [MAXC];
    int            dly [NL];
    logic [NL-1:0] hold_done;
    int            sv_at, clr_at;
    bit            sv_hold, sv_req;
    int            acc_q[$];
    int            n_outv, n_lsb;

    layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(TO), .CW(12)) dut (
        .clk(clk), .rst(rst), .sample_v(sample_v), .sample_ready(sample_ready),
        .lsb_shift(lsb_shift), .conv_start(conv_start), .conv_done(conv_done),
        .cache_shift(cache_shift), .out_capture(out_capture), .out_v(out_v),
        .busy(busy), .timeout_err(timeout_err), .err_layer(err_layer),
        .clr_err(clr_err), .last_cycles(last_cycles)
    );

    layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(TO), .CW(4)) dut_small (
        .clk(clk), .rst(rst), .sample_v(sample_v), .sample_ready(sm_ready),
        .lsb_shift(sm_lsb), .conv_start(sm_start), .conv_done(conv_done),
        .cache_shift(sm_cache), .out_capture(sm_cap), .out_v(sm_outv),
        .busy(sm_busy), .timeout_err(sm_terr), .err_layer(sm_el),
        .clr_err(clr_err), .last_cycles(sm_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic clear_exp();
        for (int c = 0; c < MAXC; c++) exp_vec[c] = IDLE_VEC;
    endtask

    // Timeline model: a sample accepted at t0 shifts at t0+1; each layer starts two
    // cycles after the previous done (or at t0+2), is done dly cycles after its start,
    // and is abandoned after TO wait cycles when done never arrives in time.
    task automatic model_sample(input int t0, output int t_free, output int lat, output int to_l);
        int s, dn, last;
        to_l = -1;
        lat  = -1;
        last = t0 + 1;
        exp_vec[t0 + 1][0] = 1'b1;
        s = t0 + 2;
        for (int i = 0; i < NL; i++) begin
            exp_vec[s][1 + i] = 1'b1;
            if (dly[i] == 0 || dly[i] > TO) begin
                last = s + TO;
                to_l = i;
                break;
            end
            dn = s + dly[i];
            if (i < NL - 1) begin
                exp_vec[dn + 1][NL + 1 + i] = 1'b1;
                s = dn + 2;
            end else begin
                last = dn + 1;
                exp_vec[last][B_CAP]  = 1'b1;
                exp_vec[last][B_OUTV] = 1'b1;
                lat = last - t0;
            end
        end
        for (int c = t0 + 1; c <= last; c++) begin
            exp_vec[c][B_BUSY] = 1'b1;
            exp_vec[c][B_RDY]  = 1'b0;
        end
        t_free = last + 1;
    endtask

    // Drives the DUT for n cycles from an aligned point (#1 after posedge),
    // recording outputs and answering each conv_start after dly cycles.
    task automatic run_window(input int n);
        int done_at [NL];
        for (int i = 0; i < NL; i++) done_at[i] = -1;
        acc_q.delete();
        n_outv = 0;
        n_lsb  = 0;
        sv_req = 1'b0;
        for (int c = 0; c < n; c++) begin
            obs_vec[c] = {sample_ready, busy, out_v, out_capture, cache_shift, conv_start, lsb_shift};
            if (out_v) n_outv++;
            if (lsb_shift) n_lsb++;
            for (int i = 0; i < NL; i++)
                if (conv_start[i] && dly[i] != 0) done_at[i] = c + dly[i];
            for (int i = 0; i < NL; i++)
                conv_done[i] = (done_at[i] == c) || hold_done[i];
            clr_err = (c == clr_at);
            if (c == sv_at) sv_req = 1'b1;
            sample_v = sv_req;
            if (sv_req && sample_ready) begin
                acc_q.push_back(c);
                if (!sv_hold) sv_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        sample_v  = 1'b0;
        conv_done = '0;
        clr_err   = 1'b0;
        clr_at    = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if ({sample_ready, busy, out_v, out_capture, cache_shift, conv_start, lsb_shift} !== IDLE_VEC) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b",
                     {sample_ready, busy, out_v, out_capture, cache_shift, conv_start, lsb_shift}, IDLE_VEC);
        end
        n_cmp++;
        if ({timeout_err, err_layer, last_cycles} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_status: got terr=%b el=%0d last=%0d want 0/0/0", timeout_err, err_layer, last_cycles);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int tf, lat, tol;
        clear_exp();
        for (int i = 0; i < NL; i++) dly[i] = 1;
        model_sample(0, tf, lat, tol);
        sv_at = 0;
        run_window(tf + 2);
        for (int c = 0; c < tf + 2; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL basic cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
        n_cmp++;
        if (last_cycles !== 12'(lat)) begin
            n_bad++;
            $display("FAIL basic_last_cycles: got %0d want %0d", last_cycles, lat);
        end
        n_cmp++;
        if (sm_last !== 4'((lat > 15) ? 15 : lat)) begin
            n_bad++;
            $display("FAIL basic_small_last: got %0d want %0d", sm_last, (lat > 15) ? 15 : lat);
        end
    endtask

    task automatic test_stale_done();
        int tf, lat, tol;
        clear_exp();
        for (int i = 0; i < NL; i++) dly[i] = 1;
        model_sample(0, tf, lat, tol);
        hold_done = 3'b010;
        sv_at = 0;
        run_window(tf + 2);
        hold_done = '0;
        for (int c = 0; c < tf + 2; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL stale_done cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
    endtask

    task automatic test_timeout();
        int tf, lat, tol;
        clear_exp();
        dly[0] = 1; dly[1] = 0; dly[2] = 1;
        model_sample(0, tf, lat, tol);
        sv_at = 0;
        run_window(tf + 3);
        for (int c = 0; c < tf + 3; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL timeout cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b1 || err_layer !== 3'(tol)) begin
            n_bad++;
            $display("FAIL timeout_flags: got terr=%b el=%0d want 1/%0d", timeout_err, err_layer, tol);
        end
        // The next sample must run normally after the abort.
        clear_exp();
        for (int i = 0; i < NL; i++) dly[i] = 1;
        model_sample(0, tf, lat, tol);
        sv_at = 0;
        run_window(tf + 2);
        for (int c = 0; c < tf + 2; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL after_timeout cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
    endtask

    task automatic test_clr_race();
        int tf, lat, tol;
        clear_exp();
        dly[0] = 1; dly[1] = 1; dly[2] = 0;
        model_sample(0, tf, lat, tol);
        sv_at  = 0;
        clr_at = tf - 1;
        run_window(tf + 2);
        for (int c = 0; c < tf + 2; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL clr_race cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b1 || err_layer !== 3'(tol)) begin
            n_bad++;
            $display("FAIL clr_race_flags: got terr=%b el=%0d want 1/%0d", timeout_err, err_layer, tol);
        end
        sv_at  = -1;
        clr_at = 0;
        run_window(2);
        n_cmp++;
        if (timeout_err !== 1'b0 || err_layer !== 3'd0) begin
            n_bad++;
            $display("FAIL clr_err: got terr=%b el=%0d want 0/0", timeout_err, err_layer);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        dly[0] = 1; dly[1] = 0; dly[2] = 1;
        sv_at = 0;
        run_window(9);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre_busy: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, out_v, out_capture, cache_shift, conv_start, lsb_shift} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_strobes: got %b want 0",
                     {busy, out_v, out_capture, cache_shift, conv_start, lsb_shift});
        end
        n_cmp++;
        if (last_cycles !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_mid_last: got %0d want 0", last_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (sample_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_ready: got rdy=%b busy=%b want 1/0", sample_ready, busy);
        end
        clear_exp();
        sv_at = -1;
        n = TO + 10;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL reset_mid_idle cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, tf, lat, tol, n;
        clear_exp();
        for (int i = 0; i < NL; i++) dly[i] = 5;
        t0 = 0;
        lat = 0;
        for (int k = 0; k < 3; k++) begin
            model_sample(t0, tf, lat, tol);
            t0 = tf;
        end
        n = t0;
        sv_hold = 1'b1;
        sv_at = 0;
        run_window(n);
        sv_hold = 1'b0;
        for (int c = 0; c < n; c++) begin
            n_cmp++;
            if (obs_vec[c] !== exp_vec[c]) begin
                n_bad++;
                $display("FAIL b2b cyc%0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
            end
        end
        n_cmp++;
        if (n_lsb != 3 || n_outv != 3) begin
            n_bad++;
            $display("FAIL b2b_counts: got lsb=%0d outv=%0d want 3/3", n_lsb, n_outv);
        end
        n_cmp++;
        if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != lat + 1) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d accepts, period %0d want %0d", acc_q.size(),
                     (acc_q.size() < 2) ? -1 : acc_q[1] - acc_q[0], lat + 1);
        end
        n_cmp++;
        if (last_cycles !== 12'(lat)) begin
            n_bad++;
            $display("FAIL b2b_last_cycles: got %0d want %0d", last_cycles, lat);
        end
        n_cmp++;
        if (sm_last !== 4'((lat > 15) ? 15 : lat)) begin
            n_bad++;
            $display("FAIL b2b_small_saturate: got %0d want %0d", sm_last, (lat > 15) ? 15 : lat);
        end
    endtask

    task automatic test_random();
        int tf, lat, tol, n;
        for (int it = 0; it < 8; it++) begin
            clear_exp();
            for (int i = 0; i < NL; i++)
                dly[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            sv_at = int'($urandom_range(0, 4));
            model_sample(sv_at, tf, lat, tol);
            n = tf + 1;
            run_window(n);
            for (int c = 0; c < n; c++) begin
                n_cmp++;
                if (obs_vec[c] !== exp_vec[c]) begin
                    n_bad++;
                    $display("FAIL random%0d cyc%0d: got %b want %b", it, c, obs_vec[c], exp_vec[c]);
                end
            end
            n_cmp++;
            if (tol >= 0) begin
                if (timeout_err !== 1'b1 || err_layer !== 3'(tol)) begin
                    n_bad++;
                    $display("FAIL random%0d_flags: got terr=%b el=%0d want 1/%0d", it, timeout_err, err_layer, tol);
                end
            end else if (last_cycles !== 12'(lat)) begin
                n_bad++;
                $display("FAIL random%0d_last: got %0d want %0d", it, last_cycles, lat);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        sample_v  = 1'b0;
        clr_err   = 1'b0;
        conv_done = '0;
        hold_done = '0;
        sv_hold   = 1'b0;
        sv_req    = 1'b0;
        sv_at     = -1;
        clr_at    = -1;
        for (int i = 0; i < NL; i++) dly[i] = 1;
        test_reset();
        test_basic();
        test_stale_done();
        test_timeout();
        test_clr_race();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
